mux_rr_arbiter: RTL and testbench
=================================

// Module: mux_rr_arbiter
// PURPOSE
//   Round-robin arbiter that shares one 4:1 mux datapath among four requesters.
//   Drives the mux select and a one-hot grant, and registers the selected input on out_data.
//   A MAX_HOLD cycle limit on any one grant prevents starvation.
//   Sits between four producer blocks and a single shared consumer.
// PARAMETERS
//   DATA_W    8   width of each data input and of out_data
//   MAX_HOLD  8   max consecutive GRANT cycles before forced rotation; legal range >= 2
// PORTS
//   clk        in   1       single clock; all state updates on its rising edge
//   rst_n      in   1       asynchronous, active-low reset
//   req        in   4       req[i]=1: requester i wants the mux; held high while it is using the mux
//   in0..in3   in   DATA_W  data of requesters 0..3
//   gnt        out  4       one-hot grant; all zero when idle
//   sel        out  2       mux select = index of granted requester (holds last value when idle)
//   out_data   out  DATA_W  registered mux output
//   out_valid  out  1       out_data carries a valid granted word
//   busy       out  1       1 while in GRANT
// BEHAVIOUR
//   Reset (async assert, deassert synchronised by user) sets these values:
//     state=IDLE, gnt=0, sel=0, out_data=0, out_valid=0, busy=0, last=3, hold_cnt=0.
//     Because last resets to 3, the first arbitration searches from index 0.
//   Round-robin pick RR(mask): first set bit of mask, searching from (last+1) mod 4 upward with wrap.
//   State IDLE:
//     If req!=0: next cycle enter GRANT with g=RR(req), gnt=onehot(g), sel=g, last=g, hold_cnt=0.
//     Otherwise stay in IDLE with gnt=0.
//   State GRANT (granted index g): each cycle, hold_cnt++ (saturates at MAX_HOLD-1).
//     release = !req[g] OR (hold_cnt==MAX_HOLD-1 AND others!=0), where others = req & ~onehot(g).
//     On release with others!=0: switch back-to-back next cycle to g'=RR(others).
//       Update gnt, sel, last; clear hold_cnt. There is no idle gap.
//     On release with others==0: go to IDLE next cycle, gnt=0.
//     Otherwise hold the grant.
//     If req[g] is still high at preemption, g rejoins arbitration as a normal requester.
//   Datapath (1-cycle latency):
//     out_data <= in[sel] every cycle while in GRANT.
//     out_valid <= (state==GRANT && req[g]).
//     In IDLE, out_valid <= 0 and out_data holds its value.
//   Fairness bound: a requester waits at most 3*MAX_HOLD cycles after asserting req.
//   Simultaneous events:
//     - A new req arriving in the same cycle as a release is included in that RR pick.
//     - A request dropped in the same cycle it would be picked is not granted (RR uses the current req).
//   Reset mid-GRANT: all outputs return to their reset values immediately, and arbitration restarts from index 0.
//   Invariants:
//     - gnt is zero or one-hot.
//     - gnt==onehot(sel) whenever busy=1.
//     - busy==|gnt.
// TESTING
//   1. Reset, req=4'b0100 held for 3 cycles, then 0 -> the grant sequence is:
//        gnt=4'b0100 and sel=2 from the cycle after req rises;
//        out_valid=1 with out_data=in2 one cycle later;
//        IDLE, gnt=0, one cycle after req falls.
//   2. req=4'b1111 held, MAX_HOLD=8 -> grants rotate 0,1,2,3,0 with each grant exactly 8 cycles long.
//        Handovers are back-to-back; busy stays 1 throughout.
//   3. req=4'b0001 held alone for 20 cycles -> gnt=4'b0001 the whole time.
//        There is no preemption because others==0; hold_cnt saturates at 7.
//   4. Grant on 1; req[1] drops in the same cycle req[3] rises -> next cycle gnt=4'b1000, sel=3, with no IDLE cycle.
//   5. In GRANT on 2 at hold_cnt=4, assert rst_n=0 asynchronously mid-cycle ->
//        gnt, sel, out_valid and busy go to 0 immediately.
//        After release with req=4'b1111, the first grant is index 0.
//   6. in0..in3 = 8'hA0, 8'hB1, 8'hC2, 8'hD3 with rotating grants -> out_data matches in[sel] of the previous cycle on every out_valid=1 cycle.
//        gnt is never multi-hot.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
//   Round-robin arbiter sharing one 4:1 mux between four requesters.
//   A grant lasts until its requester drops req, or until MAX_HOLD cycles
//   have passed while someone else is waiting. The selected input is
//   registered onto out_data with one cycle of latency.
module mux_rr_arbiter #(
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  output logic [3:0]        gnt,
  output logic [1:0]        sel,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              busy
);

  localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [3:0]        gnt_nxt;
  logic [1:0]        sel_nxt;
  logic [1:0]        last, last_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;

  logic [3:0]        others;
  logic              release_gnt;
  logic [1:0]        pick_all;
  logic [1:0]        pick_others;
  logic [DATA_W-1:0] mux_data;

  // First set bit of mask, searching upward from (from_idx+1) with wrap.
  // The loop runs from the farthest candidate to the nearest so the nearest
  // match is the last write and wins. Returns from_idx when nothing matches;
  // callers only use the result when mask is non-zero.
  function automatic logic [1:0] rr_pick(input logic [3:0] mask,
                                         input logic [1:0] from_idx);
    logic [1:0] idx;
    rr_pick = from_idx;
    for (int k = 4; k >= 1; k--) begin
      idx = from_idx + 2'(k);
      if (mask[idx]) rr_pick = idx;
    end
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    onehot = 4'b0001 << idx;
  endfunction

  // Arbitration terms: the current holder is sel while in GRANT.
  always_comb begin
    others      = req & ~onehot(sel);
    release_gnt = !req[sel] || ((hold_cnt == HOLD_LAST) && (others != 4'b0000));
    pick_all    = rr_pick(req, last);
    pick_others = rr_pick(others, last);
  end

  // Next-state and next-grant decision.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned; otherwise synthesis infers a latch to hold the old value.
    state_nxt = state;
    gnt_nxt   = gnt;
    sel_nxt   = sel;
    last_nxt  = last;
    hold_nxt  = hold_cnt;

    unique case (state)
      IDLE: begin
        gnt_nxt = 4'b0000;
        if (req != 4'b0000) begin
          state_nxt = GRANT;
          gnt_nxt   = onehot(pick_all);
          sel_nxt   = pick_all;
          last_nxt  = pick_all;
          hold_nxt  = '0;
        end
      end

      GRANT: begin
        if (hold_cnt != HOLD_LAST) hold_nxt = hold_cnt + HOLD_W'(1);
        if (release_gnt) begin
          hold_nxt = '0;
          if (others != 4'b0000) begin
            // Back-to-back handover: no idle cycle between owners.
            gnt_nxt  = onehot(pick_others);
            sel_nxt  = pick_others;
            last_nxt = pick_others;
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = 4'b0000;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 4'b0000;
      end
    endcase
  end

  // Control state register; last resets to 3 so the first search starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create ordering races.
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= 4'b0000;
      sel      <= 2'd0;
      last     <= 2'd3;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      sel      <= sel_nxt;
      last     <= last_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // Shared 4:1 mux driven by the registered select.
  always_comb begin
    mux_data = in0;
    unique case (sel)
      2'd0: mux_data = in0;
      2'd1: mux_data = in1;
      2'd2: mux_data = in2;
      2'd3: mux_data = in3;
      default: mux_data = in0;
    endcase
  end

  // Output register: captures the selected word while granted, holds in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (state == GRANT) begin
      out_data  <= mux_data;
      out_valid <= req[sel];
    end else begin
      out_valid <= 1'b0;
    end
  end

  assign busy = (state == GRANT);

`ifndef SYNTHESIS
  // Structural invariants of the grant outputs.
  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(gnt));
  a_busy_gnt : assert property (@(posedge clk) disable iff (!rst_n)
    busy == (|gnt));
  a_gnt_sel : assert property (@(posedge clk) disable iff (!rst_n)
    busy |-> (gnt == onehot(sel)));
`endif

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Testbench for mux_rr_arbiter: table of single-cycle vectors plus
// hand-written multi-cycle sequences (rotation, saturation, async reset).
module tb_mux_rr_arbiter;

  localparam int DATA_W   = 8;
  localparam int MAX_HOLD = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [3:0]        req;
  logic [DATA_W-1:0] in0, in1, in2, in3;
  logic [3:0]        gnt;
  logic [1:0]        sel;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              busy;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  logic [DATA_W-1:0] sb_q[$];

  mux_rr_arbiter #(.DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .gnt       (gnt),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] exp_gnt;
    logic [1:0] exp_sel;
    logic       exp_valid;
    logic       exp_busy;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] data_of(input logic [1:0] idx);
    case (idx)
      2'd0: data_of = 8'hA0;
      2'd1: data_of = 8'hB1;
      2'd2: data_of = 8'hC2;
      default: data_of = 8'hD3;
    endcase
  endfunction

  // One clock: outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Grant can never be multi-hot, checked every cycle while enabled.
  always @(negedge clk) begin
    if (mon_en) check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
  end

  vec_t vecs[17];

  initial begin
    logic [1:0] rot_seq[5];
    logic [1:0] prev_idx;
    bit         first;
    logic [DATA_W-1:0] exp_d;

    in0 = 8'hA0; in1 = 8'hB1; in2 = 8'hC2; in3 = 8'hD3;
    rst_n = 1'b1;
    req   = 4'b0000;

    //               req      gnt      sel valid busy
    vecs[0]  = '{4'b0100, 4'b0100, 2'd2, 1'b0, 1'b1};
    vecs[1]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
    vecs[2]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
    vecs[3]  = '{4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0};
    vecs[4]  = '{4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0};
    vecs[5]  = '{4'b0010, 4'b0010, 2'd1, 1'b0, 1'b1};
    vecs[6]  = '{4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1};
    vecs[7]  = '{4'b1000, 4'b1000, 2'd3, 1'b0, 1'b1};
    vecs[8]  = '{4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1};
    vecs[9]  = '{4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0};
    vecs[10] = '{4'b0001, 4'b0001, 2'd0, 1'b0, 1'b1};
    vecs[11] = '{4'b0100, 4'b0100, 2'd2, 1'b0, 1'b1};
    vecs[12] = '{4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0};
    vecs[13] = '{4'b0101, 4'b0001, 2'd0, 1'b0, 1'b1};
    vecs[14] = '{4'b0100, 4'b0100, 2'd2, 1'b0, 1'b1};
    vecs[15] = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
    vecs[16] = '{4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0};

    // Reset state.
    do_reset();
    #1;
    check("rst_gnt",   32'(gnt),       32'h0);
    check("rst_sel",   32'(sel),       32'h0);
    check("rst_data",  32'(out_data),  32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_busy",  32'(busy),      32'h0);
    mon_en = 1'b1;

    // Table-driven single-cycle vectors (single request, drop/raise handover,
    // RR search order, request swap on release).
    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      req = vecs[i].req;
      if (vecs[i].exp_valid && i > 0) sb_q.push_back(data_of(vecs[i-1].exp_sel));
      step();
      check($sformatf("vec%0d_gnt", i),   32'(gnt),       32'(vecs[i].exp_gnt));
      check($sformatf("vec%0d_sel", i),   32'(sel),       32'(vecs[i].exp_sel));
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_busy", i),  32'(busy),      32'(vecs[i].exp_busy));
      if (vecs[i].exp_valid && sb_q.size() > 0) begin
        exp_d = sb_q.pop_front();
        check($sformatf("vec%0d_data", i), 32'(out_data), 32'(exp_d));
      end
      @(negedge clk);
    end

    // Full contention: grants rotate 0,1,2,3,0, each MAX_HOLD cycles long.
    do_reset();
    rot_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    req     = 4'b1111;
    first   = 1'b1;
    prev_idx = 2'd0;
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < MAX_HOLD; c++) begin
        step();
        check($sformatf("rot%0d_c%0d_gnt", g, c), 32'(gnt),  32'(4'b0001 << rot_seq[g]));
        check($sformatf("rot%0d_c%0d_sel", g, c), 32'(sel),  32'(rot_seq[g]));
        check($sformatf("rot%0d_c%0d_busy", g, c), 32'(busy), 32'd1);
        check($sformatf("rot%0d_c%0d_valid", g, c), 32'(out_valid), first ? 32'd0 : 32'd1);
        if (!first && sb_q.size() > 0) begin
          exp_d = sb_q.pop_front();
          check($sformatf("rot%0d_c%0d_data", g, c), 32'(out_data), 32'(exp_d));
        end
        sb_q.push_back(data_of(rot_seq[g]));
        prev_idx = rot_seq[g];
        first = 1'b0;
      end
    end
    sb_q.delete();

    // Lone requester: no preemption, hold counter saturates at MAX_HOLD-1.
    do_reset();
    req = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      step();
      check($sformatf("solo_c%0d_gnt", c), 32'(gnt), 32'h1);
      check($sformatf("solo_c%0d_hold", c), 32'(dut.hold_cnt),
            32'((c < MAX_HOLD - 1) ? c : MAX_HOLD - 1));
    end
    // Saturated counter: a newcomer preempts on the very next edge.
    @(negedge clk);
    req = 4'b0011;
    step();
    check("solo_preempt_gnt", 32'(gnt), 32'b0010);
    check("solo_preempt_sel", 32'(sel), 32'd1);

    // Async reset mid-grant on requester 2 at hold_cnt=4.
    do_reset();
    req = 4'b0100;
    for (int c = 0; c < 5; c++) step();
    check("pre_rst_gnt",  32'(gnt),           32'b0100);
    check("pre_rst_hold", 32'(dut.hold_cnt),  32'd4);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_gnt",   32'(gnt),       32'h0);
    check("midrst_sel",   32'(sel),       32'h0);
    check("midrst_valid", 32'(out_valid), 32'h0);
    check("midrst_busy",  32'(busy),      32'h0);
    check("midrst_data",  32'(out_data),  32'h0);
    req = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("postrst_gnt", 32'(gnt), 32'b0001);
    check("postrst_sel", 32'(sel), 32'd0);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
